fifo_sum_win: RTL and testbench
===============================

Name: fifo_sum_win

Overview:
- Parametrised successor to the UART row-sum controller.
- Accepts a row-major stream of DATA_W-bit samples from the UART RX path. Samples form rows of COLS elements.
- Emits the per-column sum of the most recent ROWS rows, formatted to OUT_W bits, through an output FIFO with a valid/ready handshake to the UART TX path.
- Adds sliding/block window modes, saturation, output buffering, overflow detection and soft clear.

Parameters:
- DATA_W, 8: input sample width.
- COLS, 4: elements per row; line-buffer depth; ≥2.
- ROWS, 3: rows per window; ≥2; ROWS-1 line buffers.
- OUT_W, 8: output width.
- SAT, 1: 1 = saturate sum to 2^OUT_W-1; 0 = keep low OUT_W bits.
- MODE, 0: 0 = sliding window (output every row once primed); 1 = block (output every ROWS-th row only).
- OUT_DEPTH, 8: output FIFO depth; power of 2.

Ports:
- sys_clk, in, 1: clock.
- rst_n, in, 1: synchronous active-low reset.
- clr, in, 1: synchronous soft clear, same effect as reset.
- in_valid, in, 1: one-cycle strobe; in_data is valid. No backpressure.
- in_data, in, DATA_W: input sample.
- out_valid, out, 1: output FIFO non-empty.
- out_ready, in, 1: consumer accepts (driven from !busy_flag of TX).
- out_data, out, OUT_W: head of output FIFO.
- out_count, out, clog2(OUT_DEPTH)+1: output FIFO occupancy.
- overflow, out, 1: sticky; a result was dropped.

Behaviour:
- Reset (rst_n=0 at a sys_clk edge) or clr=1: the following all clear.
  - col_cnt=0, row_cnt=0.
  - All line-buffer and output-FIFO pointers cleared.
  - sum register cleared.
  - Outputs: out_valid=0, out_data=0, out_count=0, overflow=0.
- Reset or clr mid-row discards the partial row and all buffered data. A pending sum_vld is cancelled.
- SUM_W = DATA_W + clog2(ROWS). Unsigned arithmetic throughout.
- Counters:
  - col_cnt increments on in_valid and wraps COLS-1 -> 0.
  - row_cnt increments on each col_cnt wrap.
  - MODE 0: row_cnt saturates at ROWS-1 (primed).
  - MODE 1: row_cnt wraps ROWS-1 -> 0.
- Line buffers LB[0..ROWS-2]: first-word-fall-through FIFOs of depth COLS, cascaded.
  - On in_valid: in_data is pushed into LB0, and each LB[k] head is pushed into LB[k+1].
  - A FIFO is popped only when it holds a full row (count==COLS). The last LB head is simply discarded when popped.
  - MODE 1: after the last column of row ROWS-1, all LBs are flushed (pointers reset) so the next window starts empty.
- Window-complete condition:
  - MODE 0: row_cnt==ROWS-1.
  - MODE 1: row_cnt==ROWS-1.
- Sum: on in_valid with the window-complete condition true, sum <= in_data + heads of all LBs (SUM_W wide). sum_vld is asserted the next cycle.
- Format:
  - SAT=1: out_data_w = (sum > 2^OUT_W-1) ? all-ones : sum[OUT_W-1:0].
  - SAT=0: out_data_w = sum[OUT_W-1:0].
- Output FIFO:
  - sum_vld pushes the formatted value.
  - Latency: in_valid at edge t gives the push at t+1 and out_valid=1 after edge t+2 (when the FIFO was empty).
  - A pop occurs when out_valid && out_ready.
  - Full with a simultaneous pop: the push succeeds and the count is unchanged.
  - Full with no pop: the push is dropped and overflow <= 1 (cleared only by reset/clr).
  - Empty: out_ready is ignored and the count never underflows.
  - out_data holds the head value when !out_valid (last popped value, or 0 after reset).
- in_valid is at most one pulse per cycle. Back-to-back in_valid must be supported at full rate.

Decomposition:
- Package fifo_sum_pkg:
  - clog2 function.
  - MODE_SLIDE=0 and MODE_BLOCK=1 constants.
  - SUM_W derivation helper.
- One sub-module, sync_fifo_fwft (params WIDTH, DEPTH; ports push, pop, din, dout, count, full, empty, clr; synchronous active-low reset). It is instantiated ROWS-1 times for the line buffers and once for the output FIFO.
- Top: counters, cascade control, adder tree, formatter, overflow flag.

Test Plan (DATA_W=8, COLS=4, ROWS=3, OUT_W=8, OUT_DEPTH=8, out_ready=1 unless stated):
- Sliding sum, MODE0 SAT1:
  - Rows 1,2,3,4 / 5,6,7,8 / 9,10,11,12 -> out 15,18,21,24, nothing before row 3 completes columns.
  - Next row 0,0,0,0 -> 14,16,18,20.
- Saturation: three rows of 200 -> SAT=1 gives 255 x4; SAT=0 gives 88 x4 (600 mod 256).
- Block mode, MODE1:
  - Six rows with row r all equal to r (1..6) -> 6,6,6,6 after row 3.
  - No output during rows 4-5.
  - 15,15,15,15 after row 6.
- Backpressure: out_ready=0, produce 9 results -> out_count=8, overflow=1, first 8 values drained intact when out_ready=1. Full with simultaneous push/pop keeps count=8 and overflow=0.
- Latency: back-to-back in_valid -> out_valid rises exactly 2 cycles after the completing in_valid; one result per cycle.
- Reset/clr mid-row: rst_n=0 (one edge) after 2 samples of row 3 -> all outputs 0; subsequent rows restart priming (no output until 3 new full rows). Repeat with clr.

Source files
------------

// File: rtl/fifo_sum_win_pkg.sv
// Shared constants and elaboration-time helpers for the windowed column-sum block.
package fifo_sum_pkg;

  localparam int MODE_SLIDE = 0;
  localparam int MODE_BLOCK = 1;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Width that holds the sum of `rows` unsigned samples of `data_w` bits.
  function automatic int sum_width(input int data_w, input int rows);
    return data_w + clog2(rows);
  endfunction

endpackage

// File: rtl/fifo_sum_win_if.sv
// Sample input strobe and buffered result handshake of fifo_sum_win.
interface fifo_sum_win_if #(
  parameter int DATA_W    = 8,
  parameter int OUT_W     = 8,
  parameter int OUT_DEPTH = 8
);
  localparam int CNT_W = fifo_sum_pkg::clog2(OUT_DEPTH) + 1;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_count;
  logic              overflow;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_count, overflow
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_count, overflow
  );
endinterface

// File: rtl/fifo_sum_win_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO. Any DEPTH >= 2 is allowed; when
// empty, dout keeps the last value popped (0 after reset or clr).
module sync_fifo_fwft
  import fifo_sum_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW   = clog2(DEPTH),
  localparam int CW   = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? last_q : mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointer, occupancy and last-popped bookkeeping; clr overrides everything.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
      last_d   = mem_q[rd_ptr_q];
    end
    if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      last_d   = '0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; cleared pointers make stale words unreachable.
    if (do_push && !clr) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/fifo_sum_win.sv
// Per-column sum over the last ROWS rows of a row-major sample stream,
// formatted to OUT_W bits and buffered in an output FIFO.
module fifo_sum_win
  import fifo_sum_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int COLS      = 4,
  parameter int ROWS      = 3,
  parameter int OUT_W     = 8,
  parameter int SAT       = 1,
  parameter int MODE      = MODE_SLIDE,
  parameter int OUT_DEPTH = 8
) (
  input  logic           sys_clk,
  input  logic           rst_n,
  input  logic           clr,
  fifo_sum_win_if.slave  bus
);

  localparam int SUM_W = sum_width(DATA_W, ROWS);
  localparam int COL_W = clog2(COLS);
  localparam int ROW_W = clog2(ROWS);
  localparam int LB_CW = clog2(COLS) + 1;
  localparam int NLB   = ROWS - 1;

  logic [COL_W-1:0]  col_cnt_q, col_cnt_d;
  logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic              sum_vld_q, sum_vld_d;
  logic              overflow_q, overflow_d;
  logic              col_wrap, win_done, lb_flush, lb_clr;

  logic [DATA_W-1:0] lb_din  [NLB];
  logic [DATA_W-1:0] lb_dout [NLB];
  logic [NLB-1:0]    lb_push, lb_pop, lb_full;
  logic [NLB-1:0]    lb_empty_unused;
  logic [LB_CW-1:0]  lb_count_unused [NLB];

  logic [SUM_W+OUT_W-1:0] sum_ext;
  logic [OUT_W-1:0]       fmt_data;
  logic                   out_full, out_empty, out_pop;

  // Next state for counters, window sum and sticky overflow.
  always_comb begin
    col_wrap  = bus.in_valid && (col_cnt_q == COL_W'(COLS - 1));
    win_done  = (row_cnt_q == ROW_W'(ROWS - 1));
    lb_flush  = (MODE == MODE_BLOCK) && col_wrap && win_done;
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    if (bus.in_valid) col_cnt_d = col_wrap ? '0 : col_cnt_q + 1'b1;
    if (col_wrap) begin
      if (!win_done)               row_cnt_d = row_cnt_q + 1'b1;
      else if (MODE == MODE_BLOCK) row_cnt_d = '0;
    end
    sum_vld_d = bus.in_valid && win_done;
    sum_d     = SUM_W'(bus.in_data);
    for (int k = 0; k < NLB; k++) sum_d = sum_d + SUM_W'(lb_dout[k]);
    if (!sum_vld_d) sum_d = sum_q;
    overflow_d = overflow_q || (sum_vld_q && out_full && !out_pop);
    if (clr) begin
      col_cnt_d  = '0;
      row_cnt_d  = '0;
      sum_d      = '0;
      sum_vld_d  = 1'b0;
      overflow_d = 1'b0;
    end
  end

  // Counter, sum and flag registers.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      col_cnt_q  <= '0;
      row_cnt_q  <= '0;
      sum_q      <= '0;
      sum_vld_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      col_cnt_q  <= col_cnt_d;
      row_cnt_q  <= row_cnt_d;
      sum_q      <= sum_d;
      sum_vld_q  <= sum_vld_d;
      overflow_q <= overflow_d;
    end
  end

  // Cascaded line buffers: each holds one previous row; a full buffer hands
  // its oldest sample to the next one as a new sample arrives.
  assign lb_clr = clr || lb_flush;

  for (genvar k = 0; k < NLB; k++) begin : g_lb
    if (k == 0) begin : g_first
      assign lb_din[k]  = bus.in_data;
      assign lb_push[k] = bus.in_valid;
    end else begin : g_next
      assign lb_din[k]  = lb_dout[k-1];
      assign lb_push[k] = lb_pop[k-1];
    end
    assign lb_pop[k] = bus.in_valid && lb_full[k];

    sync_fifo_fwft #(.WIDTH(DATA_W), .DEPTH(COLS)) u_lb (
      .clk   (sys_clk),
      .rst_n (rst_n),
      .clr   (lb_clr),
      .push  (lb_push[k]),
      .pop   (lb_pop[k]),
      .din   (lb_din[k]),
      .dout  (lb_dout[k]),
      .count (lb_count_unused[k]),
      .full  (lb_full[k]),
      .empty (lb_empty_unused[k])
    );
  end

  // Reduce the sum to OUT_W bits, clamping when saturation is enabled.
  always_comb begin
    sum_ext = {{OUT_W{1'b0}}, sum_q};
    if ((SAT != 0) && ((sum_ext >> OUT_W) != '0)) fmt_data = '1;
    else                                          fmt_data = sum_ext[OUT_W-1:0];
  end

  assign out_pop = bus.out_ready && !out_empty;

  sync_fifo_fwft #(.WIDTH(OUT_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (sum_vld_q),
    .pop   (bus.out_ready),
    .din   (fmt_data),
    .dout  (bus.out_data),
    .count (bus.out_count),
    .full  (out_full),
    .empty (out_empty)
  );

  assign bus.out_valid = !out_empty;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_fifo_sum_win.sv
// Directed bench: three fifo_sum_win instances (sliding/saturate, sliding/wrap,
// block/saturate) share one stimulus stream and are each compared every cycle
// against a sample-history model of the column sums and the output queue.
`timescale 1ns/1ps
module tb_fifo_sum_win;
  import fifo_sum_pkg::*;

  localparam int DATA_W    = 8;
  localparam int COLS      = 4;
  localparam int ROWS      = 3;
  localparam int OUT_W     = 8;
  localparam int OUT_DEPTH = 8;
  localparam int CNT_W     = clog2(OUT_DEPTH) + 1;
  localparam int NI        = 3;

  logic              sys_clk = 1'b0;
  logic              rst_n_s, clr_s, in_valid_s, out_ready_s;
  logic [DATA_W-1:0] in_data_s;
  int                cyc = 0;
  int                n_chk = 0;
  int                n_err = 0;
  bit                chk_en = 1'b0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  fifo_sum_win_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .OUT_DEPTH(OUT_DEPTH)) bus_s1 ();
  fifo_sum_win_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .OUT_DEPTH(OUT_DEPTH)) bus_s0 ();
  fifo_sum_win_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .OUT_DEPTH(OUT_DEPTH)) bus_b ();

  assign bus_s1.in_valid = in_valid_s;  assign bus_s1.in_data = in_data_s;  assign bus_s1.out_ready = out_ready_s;
  assign bus_s0.in_valid = in_valid_s;  assign bus_s0.in_data = in_data_s;  assign bus_s0.out_ready = out_ready_s;
  assign bus_b.in_valid  = in_valid_s;  assign bus_b.in_data  = in_data_s;  assign bus_b.out_ready  = out_ready_s;

  fifo_sum_win #(.DATA_W(DATA_W), .COLS(COLS), .ROWS(ROWS), .OUT_W(OUT_W), .SAT(1),
                 .MODE(MODE_SLIDE), .OUT_DEPTH(OUT_DEPTH))
    u_s1 (.sys_clk(sys_clk), .rst_n(rst_n_s), .clr(clr_s), .bus(bus_s1));
  fifo_sum_win #(.DATA_W(DATA_W), .COLS(COLS), .ROWS(ROWS), .OUT_W(OUT_W), .SAT(0),
                 .MODE(MODE_SLIDE), .OUT_DEPTH(OUT_DEPTH))
    u_s0 (.sys_clk(sys_clk), .rst_n(rst_n_s), .clr(clr_s), .bus(bus_s0));
  fifo_sum_win #(.DATA_W(DATA_W), .COLS(COLS), .ROWS(ROWS), .OUT_W(OUT_W), .SAT(1),
                 .MODE(MODE_BLOCK), .OUT_DEPTH(OUT_DEPTH))
    u_b (.sys_clk(sys_clk), .rst_n(rst_n_s), .clr(clr_s), .bus(bus_b));

  logic             obs_v [NI];
  logic [OUT_W-1:0] obs_d [NI];
  logic [CNT_W-1:0] obs_c [NI];
  logic             obs_o [NI];
  assign obs_v[0] = bus_s1.out_valid; assign obs_d[0] = bus_s1.out_data;
  assign obs_c[0] = bus_s1.out_count; assign obs_o[0] = bus_s1.overflow;
  assign obs_v[1] = bus_s0.out_valid; assign obs_d[1] = bus_s0.out_data;
  assign obs_c[1] = bus_s0.out_count; assign obs_o[1] = bus_s0.overflow;
  assign obs_v[2] = bus_b.out_valid;  assign obs_d[2] = bus_b.out_data;
  assign obs_c[2] = bus_b.out_count;  assign obs_o[2] = bus_b.overflow;

  function automatic int mode_of(input int i);
    return (i == 2) ? MODE_BLOCK : MODE_SLIDE;
  endfunction

  function automatic int sat_of(input int i);
    return (i == 1) ? 0 : 1;
  endfunction

  function automatic int fmt(input int s, input int sat);
    if (sat != 0) return (s > (1 << OUT_W) - 1) ? (1 << OUT_W) - 1 : s;
    return s % (1 << OUT_W);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: all samples since the last clear, plus the queue of
  // results the consumer should see, one sum in flight between sample and queue.
  int hist   [NI][$];
  int mq     [NI][$];
  int last_m [NI];
  bit ovf_m  [NI];
  bit pend_v [NI];
  int pend_d [NI];

  always @(posedge sys_clk) begin
    bit pop;
    int n, row, s;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n_s || clr_s) begin
        hist[i].delete();
        mq[i].delete();
        last_m[i] = 0;
        ovf_m[i]  = 1'b0;
        pend_v[i] = 1'b0;
        pend_d[i] = 0;
      end else begin
        pop = (mq[i].size() > 0) && out_ready_s;
        if (pop) last_m[i] = mq[i].pop_front();
        if (pend_v[i]) begin
          if (mq[i].size() < OUT_DEPTH) mq[i].push_back(pend_d[i]);
          else                          ovf_m[i] = 1'b1;
        end
        pend_v[i] = 1'b0;
        if (in_valid_s) begin
          hist[i].push_back(int'(in_data_s));
          n   = hist[i].size() - 1;
          row = n / COLS;
          if ((mode_of(i) == MODE_SLIDE) ? (row >= ROWS - 1) : ((row % ROWS) == ROWS - 1)) begin
            s = 0;
            for (int k = 0; k < ROWS; k++) s += hist[i][n - k * COLS];
            pend_v[i] = 1'b1;
            pend_d[i] = fmt(s, sat_of(i));
          end
        end
      end
    end
  end

  // Per-cycle comparison plus a log of every value the consumer takes.
  int got     [NI][$];
  int got_cyc [$];
  int rise_cyc = -1;
  bit prev_v0  = 1'b0;

  always @(negedge sys_clk) begin
    int ev, ec, ed;
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        ec = mq[i].size();
        ev = (ec > 0) ? 1 : 0;
        ed = (ec > 0) ? mq[i][0] : last_m[i];
        check($sformatf("out_valid[%0d]", i), int'(obs_v[i]), ev);
        check($sformatf("out_count[%0d]", i), int'(obs_c[i]), ec);
        check($sformatf("out_data[%0d]", i),  int'(obs_d[i]), ed);
        check($sformatf("overflow[%0d]", i),  int'(obs_o[i]), int'(ovf_m[i]));
        if (obs_v[i] && out_ready_s) begin
          got[i].push_back(int'(obs_d[i]));
          if (i == 0) got_cyc.push_back(cyc);
        end
      end
      if (obs_v[0] && !prev_v0) rise_cyc = cyc;
      prev_v0 = obs_v[0];
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input int v);
    in_valid_s = 1'b1;
    in_data_s  = DATA_W'(v);
    tick();
    in_valid_s = 1'b0;
  endtask

  task automatic send_row(input int v);
    for (int c = 0; c < COLS; c++) send(v);
  endtask

  task automatic pulse_reset(input bit use_clr);
    if (use_clr) clr_s = 1'b1; else rst_n_s = 1'b0;
    tick();
    clr_s   = 1'b0;
    rst_n_s = 1'b1;
  endtask

  task automatic check_got(input int inst, input int base, input int exp[$], input string name);
    check({name, " count"}, got[inst].size() - base, exp.size());
    for (int k = 0; k < exp.size(); k++)
      if (base + k < got[inst].size())
        check($sformatf("%s[%0d]", name, k), got[inst][base + k], exp[k]);
  endtask

  task automatic midrow(input bit use_clr, input string name);
    int b0;
    int e[$];
    pulse_reset(1'b0);
    send_row(50);
    send_row(60);
    send(70);
    send(70);
    pulse_reset(use_clr);
    check({name, " out_valid"}, int'(bus_s1.out_valid), 0);
    check({name, " out_count"}, int'(bus_s1.out_count), 0);
    check({name, " out_data"},  int'(bus_s1.out_data),  0);
    check({name, " overflow"},  int'(bus_s1.overflow),  0);
    b0 = got[0].size();
    send_row(1);
    send_row(2);
    idle(4);
    check({name, " no early output"}, got[0].size() - b0, 0);
    send_row(3);
    idle(6);
    e = {6, 6, 6, 6};
    check_got(0, b0, e, {name, " s1"});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1, b2, t0, gc0;
    int e[$];
    rst_n_s = 1'b0; clr_s = 1'b0; in_valid_s = 1'b0; in_data_s = '0; out_ready_s = 1'b1;
    idle(2);
    rst_n_s = 1'b1;
    chk_en  = 1'b1;
    check("reset out_valid", int'(bus_s1.out_valid), 0);
    check("reset out_count", int'(bus_s1.out_count), 0);
    check("reset out_data",  int'(bus_s1.out_data),  0);
    check("reset overflow",  int'(bus_s1.overflow),  0);

    // Sliding sums, then a zero row; latency and full-rate output.
    b0 = got[0].size(); b1 = got[1].size(); b2 = got[2].size(); gc0 = got_cyc.size();
    t0 = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < COLS; c++) begin
        if (r == 2 && c == 0) t0 = cyc;
        send((r < 3) ? 4 * r + c + 1 : 0);
      end
    idle(6);
    check("latency", rise_cyc - t0, 2);
    e = {15, 18, 21, 24, 14, 16, 18, 20};
    check_got(0, b0, e, "slide s1");
    check_got(1, b1, e, "slide s0");
    e = {15, 18, 21, 24};
    check_got(2, b2, e, "slide blk");
    if (got_cyc.size() >= gc0 + 8) check("one per cycle", got_cyc[gc0 + 7] - got_cyc[gc0], 7);
    else                           check("one per cycle pops", got_cyc.size() - gc0, 8);

    // Saturation versus wrap.
    pulse_reset(1'b0);
    b0 = got[0].size(); b1 = got[1].size(); b2 = got[2].size();
    for (int r = 0; r < 3; r++) send_row(200);
    idle(6);
    e = {255, 255, 255, 255};
    check_got(0, b0, e, "sat s1");
    check_got(2, b2, e, "sat blk");
    e = {88, 88, 88, 88};
    check_got(1, b1, e, "wrap s0");

    // Block mode: rows of constant r = 1..6.
    pulse_reset(1'b0);
    b0 = got[0].size(); b2 = got[2].size();
    for (int r = 1; r <= 6; r++) send_row(r);
    idle(6);
    e = {6, 6, 6, 6, 15, 15, 15, 15};
    check_got(2, b2, e, "block blk");
    e = {6, 6, 6, 6, 9, 9, 9, 9, 12, 12, 12, 12, 15, 15, 15, 15};
    check_got(0, b0, e, "block s1");

    // Backpressure: nine results into an eight-deep FIFO.
    pulse_reset(1'b0);
    out_ready_s = 1'b0;
    b0 = got[0].size();
    for (int r = 1; r <= 4; r++) send_row(r);
    send(5);
    idle(4);
    check("bp s1 count", int'(bus_s1.out_count), 8);
    check("bp s1 overflow", int'(bus_s1.overflow), 1);
    check("bp blk count", int'(bus_b.out_count), 4);
    check("bp blk overflow", int'(bus_b.overflow), 0);
    out_ready_s = 1'b1;
    idle(12);
    e = {6, 6, 6, 6, 9, 9, 9, 9};
    check_got(0, b0, e, "bp drain s1");
    check("bp sticky overflow", int'(bus_s1.overflow), 1);

    // Full FIFO with a push and a pop on the same edge.
    pulse_reset(1'b0);
    out_ready_s = 1'b0;
    b0 = got[0].size();
    for (int r = 1; r <= 4; r++) send_row(r);
    idle(3);
    check("full s1 count", int'(bus_s1.out_count), 8);
    in_valid_s = 1'b1;
    in_data_s  = DATA_W'(5);
    tick();
    in_valid_s  = 1'b0;
    out_ready_s = 1'b1;
    tick();
    out_ready_s = 1'b0;
    check("push+pop count", int'(bus_s1.out_count), 8);
    check("push+pop overflow", int'(bus_s1.overflow), 0);
    idle(2);
    out_ready_s = 1'b1;
    idle(12);
    e = {6, 6, 6, 6, 9, 9, 9, 9, 12};
    check_got(0, b0, e, "push+pop drain s1");

    // Mid-row reset and mid-row clear.
    midrow(1'b0, "rst midrow");
    midrow(1'b1, "clr midrow");

    idle(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
